down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width in bits.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 SHALL have port Load  input  1  load request: capture Din and start a countdown.
REQ-005 SHALL have port Din  input  WIDTH  the start value, captured when Load=1.
REQ-006 SHALL have port En  input  1  step enable: one decrement per cycle while running.
REQ-007 SHALL have port Dout  output  WIDTH  the current count, registered.
REQ-008 SHALL have port Busy  output  1  high while the countdown is in progress (state RUN).
REQ-009 SHALL have port Done  output  1  a one-cycle registered pulse when the count reaches zero.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE.
REQ-011 Load=1 in any state SHALL take priority over En; next cycle Dout=Din and the reload register holds Din.
REQ-012 Load with Din!=0 SHALL go to RUN; Load with Din==0 SHALL go to DONE with Dout=0.
REQ-013 In RUN with En=1 and Dout>1, the block SHALL set Dout to Dout-1 and stay in RUN.
REQ-014 In RUN with En=1 and Dout==1, the block SHALL set Dout to 0 and go to DONE.
REQ-015 In RUN with En=0, the block SHALL hold Dout and the state.
REQ-016 Done SHALL be 1 exactly in the cycles where the state is DONE; Busy SHALL be 1 exactly when the state is RUN.
REQ-017 DONE SHALL last one cycle, then go to IDLE (or per REQ-024 when the auto-reload macro is defined), unless Load=1.
REQ-018 IDLE SHALL hold Dout; En SHALL be ignored in IDLE and DONE.
REQ-019 Dout SHALL never decrement below 0; there is no wrap from 0 to 2^WIDTH-1.
REQ-020 Load in RUN SHALL restart the countdown from the new Din without a Done pulse; the decrement in that cycle is discarded.
REQ-021 Load in DONE SHALL keep this cycle's Done pulse and then apply REQ-012.

Reset
REQ-022 RST=0 at a CLK edge SHALL force state IDLE, Dout=0, reload register=0, Busy=0 and Done=0.
REQ-023 Reset SHALL override Load and En and abort any countdown in progress; there SHALL be no Done pulse as a result of the reset.

Configuration
REQ-024 When macro DOWN_COUNTER_AUTO_RELOAD_EN is defined, DONE with Load=0 SHALL go to RUN with Dout=reload register; if the reload value is 0, it SHALL go to IDLE instead.
REQ-025 When DOWN_COUNTER_AUTO_RELOAD_EN is undefined, the reload register and the reload path SHALL be omitted, and DONE SHALL always go to IDLE (or apply Load).

Structure
REQ-026 A shared package down_counter_pkg SHALL define the state enumeration (IDLE, RUN, DONE) and the default width constant COUNT_WIDTH=4.
REQ-027 The block SHALL be a single module with no sub-modules; the next-state logic and the registers SHALL be separate processes.

Verification
REQ-028 Reset check: RST=0 for 2 cycles with Load=1, Din=5 -> Dout=0, Busy=0, Done=0 throughout.
REQ-029 Normal countdown: Load with Din=3, then En=1 constantly -> Dout 3,2,1,0; Busy high for 3 cycles; Done is a single pulse in the cycle Dout=0; then IDLE.
REQ-030 Stall and zero load: Din=2 with En toggling 1,0,1 -> Dout 2,1,1,0. Separately, Load with Din=0 -> Done pulse next cycle and Busy never high.
REQ-031 Restart priority: Load with Din=4, two decrements (Dout=2), then Load=1 and En=1 with Din=9 -> Dout=9 next cycle, no Done pulse; with WIDTH=4 and Din=15 no wrap after reaching 0.
REQ-032 Auto-reload with the macro defined: Load with Din=2 and En=1 constantly -> Dout 2,1,0,2,1,0 and a Done pulse every third cycle. Without the macro: one pulse, then IDLE.
REQ-033 Mid-run reset: RST=0 while Dout=3 in RUN -> next cycle IDLE, Dout=0, and no Done pulse.

Source files
------------

// File: rtl/down_counter_pkg.sv
// down_counter_pkg -- shared definitions for the down_counter block.
//   COUNT_WIDTH : default count width in bits
//   state_e     : controller states IDLE / RUN / DONE
package down_counter_pkg;

  localparam int unsigned COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter.sv
// down_counter -- loadable down counter with busy/done status.
//
// A Load captures Din and starts a countdown; each cycle with En=1 in RUN
// decrements the count until it reaches zero, at which point the block
// spends exactly one cycle in DONE (Done=1) before returning to IDLE.
// Load always takes priority over En and may be applied in any state.
//
// Optional feature (macro DOWN_COUNTER_AUTO_RELOAD_EN): the loaded value is
// kept in a reload register and DONE restarts the countdown from it
// (or goes to IDLE when the reload value is zero).
//
// Ports:
//   CLK  in  1      clock, rising edge
//   RST  in  1      synchronous active-low reset
//   Load in  1      capture Din and (re)start the countdown
//   Din  in  WIDTH  start value
//   En   in  1      decrement enable while running
//   Dout out WIDTH  current count (registered)
//   Busy out 1      high while in RUN
//   Done out 1      high for the single cycle spent in DONE
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             En,
  output logic [WIDTH-1:0] Dout,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (Load) begin
      // Load overrides any pending decrement; a zero start value completes at once.
      cnt_d   = Din;
      state_d = (Din != '0) ? RUN : DONE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = Din;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (En) begin
            // Treat a count of 1 (or an impossible 0) as terminal so the
            // counter can never wrap below zero.
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              cnt_d   = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            cnt_d   = reload_q;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Dout = cnt_q;
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter -- scoreboard bench for down_counter (WIDTH=4).
// Stimulus pushes the expected post-edge outputs; a monitor pops and
// compares one entry after every rising edge.
module tb_down_counter;

  localparam int unsigned W = 4;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] Din = '0;
  logic         En = 1'b0;
  logic [W-1:0] Dout;
  logic         Busy;
  logic         Done;

  down_counter #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Load (Load),
    .Din  (Din),
    .En   (En),
    .Dout (Dout),
    .Busy (Busy),
    .Done (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] dout;
    logic         busy;
    logic         done;
    int unsigned  tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned tagn     = 0;

  // Apply one cycle of inputs and record the outputs expected after the edge.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] din,
                      input logic en, input logic [W-1:0] e_dout,
                      input logic e_busy, input logic e_done);
    exp_t e;
    @(negedge CLK);
    RST  = rst;
    Load = ld;
    Din  = din;
    En   = en;
    tagn++;
    e.dout = e_dout;
    e.busy = e_busy;
    e.done = e_done;
    e.tag  = tagn;
    sb.push_back(e);
    @(posedge CLK);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (Dout !== e.dout || Busy !== e.busy || Done !== e.done) begin
        failures++;
        $display("FAIL step%0d: got Dout=%0d Busy=%b Done=%b, want Dout=%0d Busy=%b Done=%b",
                 e.tag, Dout, Busy, Done, e.dout, e.busy, e.done);
      end
    end
  end

  initial begin
    // Reset holds everything at zero despite Load=1.
    step(0, 1, 4'd5, 1, 4'd0, 0, 0);
    step(0, 1, 4'd5, 1, 4'd0, 0, 0);
    step(1, 0, 4'd0, 0, 4'd0, 0, 0);

    // Normal countdown from 3.
    step(1, 1, 4'd3, 1, 4'd3, 1, 0);
    step(1, 0, 4'd0, 1, 4'd2, 1, 0);
    step(1, 0, 4'd0, 1, 4'd1, 1, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    if (AR) step(1, 0, 4'd0, 1, 4'd3, 1, 0);
    else    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Stall: 2,1,1,0.
    step(1, 1, 4'd2, 0, 4'd2, 1, 0);
    step(1, 0, 4'd0, 1, 4'd1, 1, 0);
    step(1, 0, 4'd0, 0, 4'd1, 1, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Zero load: straight to DONE, never busy; En ignored in IDLE.
    step(1, 1, 4'd0, 1, 4'd0, 0, 1);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);

    // Restart priority: reload in RUN discards the decrement, no Done.
    step(1, 1, 4'd4, 1, 4'd4, 1, 0);
    step(1, 0, 4'd0, 1, 4'd3, 1, 0);
    step(1, 0, 4'd0, 1, 4'd2, 1, 0);
    step(1, 1, 4'd9, 1, 4'd9, 1, 0);
    step(1, 0, 4'd0, 0, 4'd9, 1, 0);

    // Full-scale countdown from 15 with no wrap past zero.
    step(1, 1, 4'd15, 1, 4'd15, 1, 0);
    for (int k = 14; k >= 1; k--) step(1, 0, 4'd0, 1, 4'(k), 1, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    if (AR) step(1, 0, 4'd0, 1, 4'd15, 1, 0);
    else    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    if (AR) step(1, 0, 4'd0, 1, 4'd14, 1, 0);
    else    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Load in DONE keeps this cycle's pulse, then restarts.
    step(1, 1, 4'd1, 0, 4'd1, 1, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    step(1, 1, 4'd2, 1, 4'd2, 1, 0);
    step(1, 0, 4'd0, 1, 4'd1, 1, 0);
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Auto-reload sequence 2,1,0,2,1,0 (or one pulse then IDLE).
    step(1, 1, 4'd2, 1, 4'd2, 1, 0);
    step(1, 0, 4'd0, 1, 4'd1, 1, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    if (AR) begin
      step(1, 0, 4'd0, 1, 4'd2, 1, 0);
      step(1, 0, 4'd0, 1, 4'd1, 1, 0);
      step(1, 0, 4'd0, 1, 4'd0, 0, 1);
    end else begin
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);
      step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    end
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Mid-run reset at Dout=3: abort, no Done pulse.
    step(1, 1, 4'd5, 1, 4'd5, 1, 0);
    step(1, 0, 4'd0, 1, 4'd4, 1, 0);
    step(1, 0, 4'd0, 1, 4'd3, 1, 0);
    step(0, 0, 4'd0, 1, 4'd0, 0, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    #2;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
